// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave in front of a word-organised register-file memory with byte/half/word access.
// Optional feature: define AHB_WAIT_STATE_EN to insert WAIT_CYCLES wait states on every OKAY beat.
module ahb_slave_mem #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           DEPTH       = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = {ADDR_WIDTH{1'b0}},
    parameter int unsigned           WAIT_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_hsel,
    input  logic [ADDR_WIDTH-1:0] i_haddr,
    input  logic [1:0]            i_htrans,
    input  logic                  i_hwrite,
    input  logic [2:0]            i_hsize,
    input  logic [2:0]            i_hburst,
    input  logic [3:0]            i_hprot,
    input  logic [DATA_WIDTH-1:0] i_hwdata,
    input  logic                  i_hready,
    output logic                  o_hreadyout,
    output logic                  o_hresp,
    output logic [DATA_WIDTH-1:0] o_hrdata
);

    localparam int unsigned           IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(DEPTH * 4);
`ifdef AHB_WAIT_STATE_EN
    localparam bit          WAIT_EN = (WAIT_CYCLES != 0);
    localparam int unsigned CNT_W   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
`else
    localparam bit          WAIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DATA = 3'd1,
        S_WAIT = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    function automatic logic [3:0] lane_strobe(input logic [2:0] size, input logic [1:0] lsb);
        case (size)
            3'b000:  return 4'b0001 << lsb;
            3'b001:  return 4'b0011 << lsb;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] base,
                                                          input logic [DATA_WIDTH-1:0] data,
                                                          input logic [3:0]            strb);
        logic [DATA_WIDTH-1:0] res;
        res = base;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = data[8*b +: 8];
            end else begin
                res[8*b +: 8] = base[8*b +: 8];
            end
        end
        return res;
    endfunction

    state_t                  state_r;
    logic [IDX_W-1:0]        dp_idx_r;
    logic                    dp_write_r;
    logic [3:0]              dp_strb_r;
`ifdef AHB_WAIT_STATE_EN
    logic [CNT_W-1:0]        wait_cnt_r;
`endif
    logic                    pend_valid_r;
    logic [IDX_W-1:0]        pend_idx_r;
    logic [DATA_WIDTH-1:0]   pend_data_r;
    logic [3:0]              pend_strb_r;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

    logic                    take_s;
    logic [ADDR_WIDTH-1:0]   off_s;
    logic                    dec_err_s;
    logic [IDX_W-1:0]        dec_idx_s;
    logic [3:0]              dec_strb_s;
    logic                    wait_done_s;
    logic                    cap_s;
    logic                    rd_load_s;
    logic [IDX_W-1:0]        rd_idx_s;
    logic [DATA_WIDTH-1:0]   mem_word_s;
    logic [DATA_WIDTH-1:0]   pend_word_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;
    logic                    unused_s;

    assign unused_s = ^{i_hburst, i_hprot, i_htrans[0], 32'(WAIT_CYCLES)};

    // Address-phase decode: accept qualification, range/size/alignment error, index and strobes.
    always_comb begin
        take_s     = i_hsel & i_hready & i_htrans[1] &
                     ((state_r == S_IDLE) | (state_r == S_DATA) | (state_r == S_ERR2));
        off_s      = i_haddr - BASE_ADDR;
        dec_idx_s  = off_s[IDX_W+1:2];
        dec_strb_s = lane_strobe(i_hsize, i_haddr[1:0]);
        dec_err_s  = (i_haddr < BASE_ADDR) | (off_s >= MEM_BYTES) | (i_hsize > 3'b010) |
                     ((i_hsize == 3'b001) & i_haddr[0]) |
                     ((i_hsize == 3'b010) & (i_haddr[1:0] != 2'b00));
    end

    // Read-data source: forward the write being captured, then the pending write, then memory.
    always_comb begin
`ifdef AHB_WAIT_STATE_EN
        wait_done_s = (state_r == S_WAIT) & (wait_cnt_r == CNT_W'(1));
`else
        wait_done_s = 1'b0;
`endif
        cap_s     = (state_r == S_DATA) & dp_write_r;
        rd_load_s = (take_s & ~dec_err_s & ~i_hwrite & ~WAIT_EN) | (wait_done_s & ~dp_write_r);
        if (wait_done_s) begin
            rd_idx_s = dp_idx_r;
        end else begin
            rd_idx_s = dec_idx_s;
        end
        mem_word_s = mem_r[rd_idx_s];
        if (pend_valid_r && (pend_idx_r == rd_idx_s)) begin
            pend_word_s = merge_lanes(mem_word_s, pend_data_r, pend_strb_r);
        end else begin
            pend_word_s = mem_word_s;
        end
        if (cap_s && (dp_idx_r == rd_idx_s)) begin
            rd_word_s = merge_lanes(pend_word_s, i_hwdata, dp_strb_r);
        end else begin
            rd_word_s = pend_word_s;
        end
    end

    // Transfer FSM with registered HREADYOUT/HRESP and data-phase capture.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r     <= S_IDLE;
            o_hreadyout <= 1'b1;
            o_hresp     <= 1'b0;
            dp_idx_r    <= {IDX_W{1'b0}};
            dp_write_r  <= 1'b0;
            dp_strb_r   <= 4'b0000;
`ifdef AHB_WAIT_STATE_EN
            wait_cnt_r  <= {CNT_W{1'b0}};
`endif
        end else begin
            case (state_r)
                S_IDLE, S_DATA, S_ERR2: begin
                    if (take_s) begin
                        dp_idx_r   <= dec_idx_s;
                        dp_write_r <= i_hwrite;
                        dp_strb_r  <= dec_strb_s;
                        if (dec_err_s) begin
                            state_r     <= S_ERR1;
                            o_hreadyout <= 1'b0;
                            o_hresp     <= 1'b1;
                        end
`ifdef AHB_WAIT_STATE_EN
                        else if (WAIT_EN) begin
                            state_r     <= S_WAIT;
                            o_hreadyout <= 1'b0;
                            o_hresp     <= 1'b0;
                            wait_cnt_r  <= CNT_W'(WAIT_CYCLES);
                        end
`endif
                        else begin
                            state_r     <= S_DATA;
                            o_hreadyout <= 1'b1;
                            o_hresp     <= 1'b0;
                        end
                    end else begin
                        state_r     <= S_IDLE;
                        o_hreadyout <= 1'b1;
                        o_hresp     <= 1'b0;
                    end
                end
`ifdef AHB_WAIT_STATE_EN
                S_WAIT: begin
                    if (wait_cnt_r == CNT_W'(1)) begin
                        state_r     <= S_DATA;
                        o_hreadyout <= 1'b1;
                        o_hresp     <= 1'b0;
                    end else begin
                        wait_cnt_r  <= wait_cnt_r - CNT_W'(1);
                        o_hreadyout <= 1'b0;
                        o_hresp     <= 1'b0;
                    end
                end
`endif
                S_ERR1: begin
                    state_r     <= S_ERR2;
                    o_hreadyout <= 1'b1;
                    o_hresp     <= 1'b1;
                end
                default: begin
                    state_r     <= S_IDLE;
                    o_hreadyout <= 1'b1;
                    o_hresp     <= 1'b0;
                end
            endcase
        end
    end

    // Pending-write register: holds the captured write for one cycle until it commits.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pend_valid_r <= 1'b0;
            pend_idx_r   <= {IDX_W{1'b0}};
            pend_data_r  <= {DATA_WIDTH{1'b0}};
            pend_strb_r  <= 4'b0000;
        end else begin
            pend_valid_r <= cap_s;
            if (cap_s) begin
                pend_idx_r  <= dp_idx_r;
                pend_data_r <= i_hwdata;
                pend_strb_r <= dp_strb_r;
            end else begin
                pend_idx_r  <= pend_idx_r;
                pend_data_r <= pend_data_r;
                pend_strb_r <= pend_strb_r;
            end
        end
    end

    // Memory array: byte-lane commit of the pending write; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset && pend_valid_r) begin
            for (int b = 0; b < 4; b++) begin
                if (pend_strb_r[b]) begin
                    mem_r[pend_idx_r][8*b +: 8] <= pend_data_r[8*b +: 8];
                end
            end
        end
    end

    // Read-data register, loaded on entry to the data cycle of an OKAY read.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_hrdata <= {DATA_WIDTH{1'b0}};
        end else if (rd_load_s) begin
            o_hrdata <= rd_word_s;
        end else begin
            o_hrdata <= o_hrdata;
        end
    end

endmodule
